// File: rtl/sha256_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha256_pkg : shared types and constants for the SHA-256 block controller
// Rev 1.0
// ----------------------------------------------------------------------------
package sha256_pkg;

  localparam int WW     = 32;
  localparam int ROUNDS = 64;
  localparam int CW     = $clog2(ROUNDS);

  typedef logic [WW-1:0]       word_t;
  typedef logic [7:0][WW-1:0]  hstate_t;
  typedef logic [15:0][WW-1:0] block_t;
  typedef logic [3:0][WW-1:0]  wtaps_t;

  typedef enum logic [1:0] {
    CS_IDLE  = 2'd0,
    CS_ISSUE = 2'd1,
    CS_WAIT  = 2'd2,
    CS_DONE  = 2'd3
  } ctrl_state_t;

  // Element 0 is H0 (6a09e667); element 7 is H7.
  localparam hstate_t IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

endpackage
`default_nettype wire

// File: rtl/sha256_block_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha256_block_ctrl_if : block, digest and round-core signals of the controller
// Rev 1.0
// ----------------------------------------------------------------------------
interface sha256_block_ctrl_if;
  import sha256_pkg::*;

  logic          blk_valid;
  logic          blk_ready;
  logic          blk_first;
  block_t        blk_w;
  logic          dig_valid;
  logic          dig_ready;
  hstate_t       dig_h;
  hstate_t       core_letters;
  logic [CW-1:0] core_counter;
  wtaps_t        core_w;
  logic          core_ready;
  hstate_t       core_letters_in;
  logic          core_letters_vld;
  word_t         core_w_in;
  logic          core_w_vld;

  // Controller side.
  modport slave (
    input  blk_valid, blk_first, blk_w, dig_ready,
           core_letters_in, core_letters_vld, core_w_in, core_w_vld,
    output blk_ready, dig_valid, dig_h,
           core_letters, core_counter, core_w, core_ready
  );

  // Front-end and round-core side.
  modport master (
    output blk_valid, blk_first, blk_w, dig_ready,
           core_letters_in, core_letters_vld, core_w_in, core_w_vld,
    input  blk_ready, dig_valid, dig_h,
           core_letters, core_counter, core_w, core_ready
  );

endinterface
`default_nettype wire

// File: rtl/sha256_wbuf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha256_wbuf : 16-word circular message schedule window with 4 read taps
// Rev 1.0
// ----------------------------------------------------------------------------
module sha256_wbuf
  import sha256_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  block_t     load_w,
  input  logic       we,
  input  logic [3:0] t,
  input  word_t      wdata,
  output wtaps_t     taps
);

  // Slot t mod 16 holds W[t-16]; +1, +9, +14 give W[t-15], W[t-7], W[t-2].
  localparam logic [15:0] TAP_OFS = {4'd14, 4'd9, 4'd1, 4'd0};

  block_t mem;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem <= '0;
    end else if (load) begin
      mem <= load_w;
    end else if (we) begin
      mem[t] <= wdata;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_tap
    logic [3:0] idx;
    assign idx     = 4'(t + TAP_OFS[4*k +: 4]);
    assign taps[k] = mem[idx];
  end

endmodule
`default_nettype wire

// File: rtl/sha256_block_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha256_block_ctrl : sequences the shared round core through one 512-bit block
// Rev 1.0
// ----------------------------------------------------------------------------
module sha256_block_ctrl
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  sha256_block_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = CS_IDLE;
  localparam logic [1:0] ST_ISSUE = CS_ISSUE;
  localparam logic [1:0] ST_WAIT  = CS_WAIT;
  localparam logic [1:0] ST_DONE  = CS_DONE;

  logic [1:0]    state;
  logic [CW-1:0] counter;
  hstate_t       letters;
  hstate_t       h_st;
  hstate_t       dig_sum;
  hstate_t       let_pend;
  word_t         w_pend;
  logic          let_ok;
  logic          w_ok;

  logic          t_hi;
  logic          let_have;
  logic          w_have;
  logic          advance;
  logic          accept;
  hstate_t       let_next;
  word_t         w_next;

  assign t_hi     = (counter >= CW'(16));
  assign accept   = (state == ST_IDLE) && bus.blk_valid;

  // Results are parked until both halves arrive so core inputs stay frozen in WAIT.
  assign let_have = let_ok || bus.core_letters_vld;
  assign w_have   = !t_hi || w_ok || bus.core_w_vld;
  assign advance  = (state == ST_WAIT) && let_have && w_have;
  assign let_next = let_ok ? let_pend : bus.core_letters_in;
  assign w_next   = w_ok ? w_pend : bus.core_w_in;

  sha256_wbuf u_wbuf (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .load_w (bus.blk_w),
    .we     (advance && t_hi),
    .t      (counter[3:0]),
    .wdata  (w_next),
    .taps   (bus.core_w)
  );

  for (genvar i = 0; i < 8; i++) begin : g_dig
    assign dig_sum[i] = h_st[i] + letters[i];
  end

  assign bus.blk_ready    = (state == ST_IDLE);
  assign bus.dig_valid    = (state == ST_DONE);
  assign bus.dig_h        = dig_sum;
  assign bus.core_letters = letters;
  assign bus.core_counter = counter;
  assign bus.core_ready   = (state == ST_ISSUE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      counter  <= '0;
      letters  <= IV;
      h_st     <= IV;
      let_pend <= '0;
      w_pend   <= '0;
      let_ok   <= 1'b0;
      w_ok     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.blk_valid) begin
            if (bus.blk_first) begin
              h_st <= IV;
            end
            letters <= bus.blk_first ? IV : h_st;
            counter <= '0;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          let_ok <= 1'b0;
          w_ok   <= 1'b0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.core_letters_vld && !let_ok) begin
            let_pend <= bus.core_letters_in;
            let_ok   <= 1'b1;
          end
          if (bus.core_w_vld && t_hi && !w_ok) begin
            w_pend <= bus.core_w_in;
            w_ok   <= 1'b1;
          end
          if (advance) begin
            letters <= let_next;
            if (counter == CW'(ROUNDS - 1)) begin
              state <= ST_DONE;
            end else begin
              counter <= counter + 1'b1;
              state   <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          if (bus.dig_ready) begin
            h_st  <= dig_sum;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_block_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sha256_block_ctrl : directed bench with a behavioural round core
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sha256_block_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sha256_block_ctrl_if bus ();

  sha256_block_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total     = 0;
  int bad       = 0;
  int order_mode = 0;
  int force_lat = 0;
  int rdy_cnt   = 0;
  int seq_bad   = 0;

  logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [7:0][31:0] dig8(input logic [255:0] be);
    logic [7:0][31:0] r;
    for (int i = 0; i < 8; i++) r[i] = be[255-32*i -: 32];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural round core: one round per core_ready, results after 1-4 cycles.
  initial begin : core_model
    logic [7:0][31:0] res;
    logic [3:0][31:0] cw;
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, wt, wres;
    int dl, dw, t;
    dl = 0; dw = 0;
    bus.core_letters_vld = 1'b0;
    bus.core_w_vld       = 1'b0;
    bus.core_letters_in  = '0;
    bus.core_w_in        = '0;
    forever begin
      @(negedge clk);
      bus.core_letters_vld = 1'b0;
      bus.core_w_vld       = 1'b0;
      if (dl > 0) begin
        dl--;
        if (dl == 0) begin bus.core_letters_in = res; bus.core_letters_vld = 1'b1; end
      end
      if (dw > 0) begin
        dw--;
        if (dw == 0) begin bus.core_w_in = wres; bus.core_w_vld = 1'b1; end
      end
      if (bus.core_ready) begin
        if (bus.core_counter != 6'(rdy_cnt % 64)) seq_bad++;
        rdy_cnt++;
        t  = int'(bus.core_counter);
        cw = bus.core_w;
        {h, g, f, e, d, c, b, a} = bus.core_letters;
        if (t < 16) wt = cw[0];
        else wt = (rotr(cw[3], 17) ^ rotr(cw[3], 19) ^ (cw[3] >> 10)) + cw[2]
                + (rotr(cw[1], 7) ^ rotr(cw[1], 18) ^ (cw[1] >> 3)) + cw[0];
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + wt;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        res  = {g, f, e, d + t1, c, b, a, t1 + t2};
        wres = (t < 16) ? 32'hdeadbeef : wt;
        if (force_lat > 0) begin
          dl = force_lat; dw = force_lat;
        end else if (order_mode == 1) begin
          dw = 1; dl = int'($urandom_range(4, 2));
        end else if (order_mode == 2) begin
          dl = 1; dw = int'($urandom_range(4, 2));
        end else begin
          dl = int'($urandom_range(4, 1)); dw = int'($urandom_range(4, 1));
        end
      end
    end
  end

  task automatic send_block(input logic first, input logic [15:0][31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    bus.blk_valid = 1'b1;
    bus.blk_first = first;
    bus.blk_w     = w;
    while (!bus.blk_ready && n < 5000) begin @(negedge clk); n++; end
    chk("blk_accept_timeout", 256'(bus.blk_ready), 256'(1'b1));
    @(negedge clk);
    bus.blk_valid = 1'b0;
  endtask

  task automatic get_digest(output logic [7:0][31:0] dg);
    int n;
    n = 0;
    bus.dig_ready = 1'b1;
    while (!bus.dig_valid && n < 5000) begin @(negedge clk); n++; end
    chk("dig_valid_timeout", 256'(bus.dig_valid), 256'(1'b1));
    dg = bus.dig_h;
    @(negedge clk);
    bus.dig_ready = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [15:0][31:0] abc, empty, m1, m2;
    logic [7:0][31:0]  iv, dig_abc, dig_empty, dig_two, dg;
    logic [31:0] msg [14] = '{
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
      32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071
    };
    int n;

    iv        = dig8(256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19);
    dig_abc   = dig8(256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
    dig_empty = dig8(256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855);
    dig_two   = dig8(256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1);
    abc = '0;   abc[0] = 32'h61626380;  abc[15] = 32'h00000018;
    empty = '0; empty[0] = 32'h80000000;
    m1 = '0;
    for (int i = 0; i < 14; i++) m1[i] = msg[i];
    m1[14] = 32'h80000000;
    m2 = '0;    m2[15] = 32'h000001c0;

    bus.blk_valid = 1'b0;
    bus.blk_first = 1'b0;
    bus.blk_w     = '0;
    bus.dig_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_blk_ready", 256'(bus.blk_ready), 256'(1'b1));
    chk("rst_dig_valid", 256'(bus.dig_valid), 256'(1'b0));
    chk("rst_core_ready", 256'(bus.core_ready), 256'(1'b0));
    chk("rst_counter", 256'(bus.core_counter), 256'(0));
    chk("rst_letters", bus.core_letters, iv);
    rst = 1'b1;

    // Test 1: "abc", random latencies
    rdy_cnt = 0; seq_bad = 0; order_mode = 0;
    send_block(1'b1, abc);
    get_digest(dg);
    chk("abc_digest", dg, dig_abc);
    chk("abc_ready_count", 256'(rdy_cnt), 256'(64));
    chk("abc_counter_seq", 256'(seq_bad), 256'(0));

    // Test 2: empty message
    send_block(1'b1, empty);
    get_digest(dg);
    chk("empty_digest", dg, dig_empty);

    // Test 3: two chained blocks
    send_block(1'b1, m1);
    get_digest(dg);
    send_block(1'b0, m2);
    get_digest(dg);
    chk("two_block_digest", dg, dig_two);

    // Test 4: digest backpressure with a next block already offered
    send_block(1'b1, abc);
    @(negedge clk);
    bus.blk_valid = 1'b1;
    bus.blk_first = 1'b1;
    bus.blk_w     = empty;
    n = 0;
    while (!bus.dig_valid && n < 5000) begin @(negedge clk); n++; end
    chk("bp_dig_valid", 256'(bus.dig_valid), 256'(1'b1));
    for (int i = 0; i < 20; i++) begin
      chk("bp_dig_h", bus.dig_h, dig_abc);
      chk("bp_blk_ready", 256'(bus.blk_ready), 256'(1'b0));
      chk("bp_dig_hold", 256'(bus.dig_valid), 256'(1'b1));
      @(negedge clk);
    end
    bus.dig_ready = 1'b1;
    @(negedge clk);
    bus.dig_ready = 1'b0;
    chk("bp_idle_blk_ready", 256'(bus.blk_ready), 256'(1'b1));
    chk("bp_idle_dig_valid", 256'(bus.dig_valid), 256'(1'b0));
    @(negedge clk);
    bus.blk_valid = 1'b0;
    chk("bp_next_accepted", 256'(bus.blk_ready), 256'(1'b0));
    get_digest(dg);
    chk("bp_next_digest", dg, dig_empty);

    // Test 5: W result strictly before letters, then letters strictly before W
    rdy_cnt = 0; seq_bad = 0; order_mode = 1;
    send_block(1'b1, abc);
    get_digest(dg);
    chk("wfirst_digest", dg, dig_abc);
    chk("wfirst_ready_count", 256'(rdy_cnt), 256'(64));
    chk("wfirst_counter_seq", 256'(seq_bad), 256'(0));
    rdy_cnt = 0; seq_bad = 0; order_mode = 2;
    send_block(1'b1, abc);
    get_digest(dg);
    chk("lfirst_digest", dg, dig_abc);
    chk("lfirst_ready_count", 256'(rdy_cnt), 256'(64));
    chk("lfirst_counter_seq", 256'(seq_bad), 256'(0));
    order_mode = 0;

    // Test 6: reset at round 30 with the core response still outstanding
    force_lat = 4;
    send_block(1'b1, abc);
    n = 0;
    while (!(bus.core_ready && bus.core_counter == 6'd30) && n < 5000) begin @(negedge clk); n++; end
    chk("r30_reached", 256'(bus.core_counter), 256'(30));
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("r30_dig_valid", 256'(bus.dig_valid), 256'(1'b0));
    chk("r30_blk_ready", 256'(bus.blk_ready), 256'(1'b1));
    chk("r30_core_ready", 256'(bus.core_ready), 256'(1'b0));
    chk("r30_counter", 256'(bus.core_counter), 256'(0));
    repeat (6) @(negedge clk);
    force_lat = 0;
    chk("stale_blk_ready", 256'(bus.blk_ready), 256'(1'b1));
    chk("stale_letters", bus.core_letters, iv);
    chk("stale_counter", 256'(bus.core_counter), 256'(0));
    send_block(1'b0, abc);
    get_digest(dg);
    chk("post_reset_digest", dg, dig_abc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
